// File: rtl/updown_buttons.sv
// ============================================================================
// Module      : updown_buttons
// Description : Synchronizes and debounces two push-buttons and emits single
//               inc/dec pulses per press, with delayed auto-repeat on hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_buttons #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_dn,
  output logic inc,
  output logic dec,
  output logic up_db,
  output logic dn_db
);

  localparam logic [15:0] c_DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] c_DELAY   = 16'(REPEAT_DELAY);
  localparam logic [15:0] c_RATE    = 16'(REPEAT_RATE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_db;

  assign w_raw = {btn_dn, btn_up};

  // Index 0 is the up button, index 1 the down button.
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic        r_s1;
    logic        r_s2;
    logic        r_db;
    logic [15:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1  <= 1'b0;
        r_s2  <= 1'b0;
        r_db  <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_s1 <= w_raw[i];
        r_s2 <= r_s1;
        if (r_s2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          r_db  <= ~r_db;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end

    assign w_db[i] = r_db;
  end

  logic   w_up_req;
  logic   w_dn_req;
  logic   w_dir_req;
  state_t r_state;
  state_t w_state_nxt;
  logic   r_dir;
  logic   w_dir_nxt;
  logic [15:0] r_timer;
  logic [15:0] w_timer_nxt;
  logic   r_inc;
  logic   r_dec;
  logic   w_inc_nxt;
  logic   w_dec_nxt;

  assign w_up_req  = w_db[0] & ~w_db[1];
  assign w_dn_req  = w_db[1] & ~w_db[0];
  // r_dir: 0 = up, 1 = down
  assign w_dir_req = r_dir ? w_dn_req : w_up_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_timer <= '0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_timer <= w_timer_nxt;
      r_inc   <= w_inc_nxt;
      r_dec   <= w_dec_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_timer_nxt = r_timer;
    w_inc_nxt   = 1'b0;
    w_dec_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_up_req) begin
          w_inc_nxt   = 1'b1;
          w_dir_nxt   = 1'b0;
          w_timer_nxt = c_DELAY;
          w_state_nxt = S_DELAY;
        end else if (w_dn_req) begin
          w_dec_nxt   = 1'b1;
          w_dir_nxt   = 1'b1;
          w_timer_nxt = c_DELAY;
          w_state_nxt = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        // Any loss of the latched request returns to IDLE without a pulse.
        if (!w_dir_req) begin
          w_state_nxt = S_IDLE;
        end else if (r_timer == 16'd1) begin
          w_inc_nxt   = ~r_dir;
          w_dec_nxt   = r_dir;
          w_timer_nxt = c_RATE;
          w_state_nxt = S_REPEAT;
        end else begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign inc   = r_inc;
  assign dec   = r_dec;
  assign up_db = w_db[0];
  assign dn_db = w_db[1];

endmodule

`default_nettype wire

// File: tb/tb_updown_buttons.sv
// ============================================================================
// Module      : tb_updown_buttons
// Description : Directed and random stimulus for updown_buttons, checked
//               against a window/run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_buttons;

  localparam int DB   = 4;
  localparam int DLY  = 16;
  localparam int RATE = 4;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic btn_up = 1'b0;
  logic btn_dn = 1'b0;
  logic inc;
  logic dec;
  logic up_db;
  logic dn_db;

  updown_buttons #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_RATE    (RATE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_up(btn_up),
    .btn_dn(btn_dn),
    .inc   (inc),
    .dec   (dec),
    .up_db (up_db),
    .dn_db (dn_db)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Reference model: bit 0 = up, bit 1 = down
  logic [1:0]  m_s1, m_s2, m_db;
  logic [15:0] m_hist [2];
  int          m_hv   [2];
  int          m_run, m_prev;
  logic        m_inc, m_dec;

  // Per-phase observation stats: 0 inc, 1 dec, 2 up_db, 3 dn_db
  int edge_no;
  int fst [4];
  int lst [4];
  int cnt [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0;
    for (int b = 0; b < 2; b++) begin
      m_hist[b] = '0;
      m_hv[b]   = 0;
    end
    m_run = 0; m_prev = 0; m_inc = 1'b0; m_dec = 1'b0;
  endtask

  // Predicts the state after the next rising edge, which samples u/d.
  task automatic model_advance(input logic u, input logic d);
    logic [1:0] raw;
    int         req;
    logic       all_diff;
    int         k;
    raw = {d, u};
    req = (m_db == 2'b01) ? 1 : (m_db == 2'b10) ? 2 : 0;
    for (int b = 0; b < 2; b++) begin
      m_hist[b] = {m_hist[b][14:0], m_s2[b]};
      if (m_hv[b] < 16) m_hv[b]++;
      all_diff = (m_hv[b] >= DB);
      for (int j = 0; j < DB; j++)
        if (m_hist[b][j] == m_db[b]) all_diff = 1'b0;
      if (all_diff) m_db[b] = ~m_db[b];
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
    if (req == 0) m_run = 0;
    else if (m_prev != 0 && m_prev != req) m_run = 0;
    else m_run++;
    m_inc = 1'b0;
    m_dec = 1'b0;
    if (m_run > 0) begin
      k = m_run - 1;
      if (k == 0 || k == DLY || (k > DLY && (k - DLY) % RATE == 0)) begin
        if (req == 1) m_inc = 1'b1;
        else m_dec = 1'b1;
      end
    end
    m_prev = req;
  endtask

  task automatic phase_start();
    edge_no = 0;
    for (int j = 0; j < 4; j++) begin
      fst[j] = -1; lst[j] = -1; cnt[j] = 0;
    end
  endtask

  task automatic step(input logic u, input logic d);
    logic [3:0] o;
    @(negedge clk);
    o = {inc, dec, up_db, dn_db};
    chk("outputs{inc,dec,up_db,dn_db}", 32'(o), 32'({m_inc, m_dec, m_db[0], m_db[1]}));
    if (edge_no > 0)
      for (int j = 0; j < 4; j++)
        if (o[3-j]) begin
          cnt[j]++;
          if (fst[j] < 0) fst[j] = edge_no - 1;
          lst[j] = edge_no - 1;
        end
    btn_up = u;
    btn_dn = d;
    model_advance(u, d);
    edge_no++;
  endtask

  task automatic hold(input logic u, input logic d, input int n);
    repeat (n) step(u, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_async", 32'({inc, dec, up_db, dn_db}), 32'd0);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("reset_hold", 32'({inc, dec, up_db, dn_db}), 32'd0);
    end
    rst = 1'b0;
    model_advance(btn_up, btn_dn);
    phase_start();
    edge_no = 1;
  endtask

  initial begin
    int r, len;
    logic u, d;
    phase_start();
    do_reset();
    hold(0, 0, 8);

    // Single press
    phase_start();
    hold(1, 0, 10);
    hold(0, 0, 15);
    chk("single_first_inc_edge", 32'(fst[0]), 32'(6));
    chk("single_inc_count", 32'(cnt[0]), 32'(1));
    chk("single_dec_count", 32'(cnt[1]), 32'(0));

    // Glitch reject
    phase_start();
    hold(0, 1, 3);
    hold(0, 0, 12);
    chk("glitch_dn_db_count", 32'(cnt[3]), 32'(0));
    chk("glitch_pulse_count", 32'(cnt[0] + cnt[1]), 32'(0));

    // Auto-repeat
    phase_start();
    hold(1, 0, 40);
    hold(0, 0, 20);
    chk("repeat_first_inc_edge", 32'(fst[0]), 32'(6));
    chk("repeat_inc_count", 32'(cnt[0]), 32'(7));
    chk("repeat_last_inc_edge", 32'(lst[0]), 32'(42));
    chk("repeat_up_db_rise", 32'(fst[2]), 32'(5));
    chk("repeat_up_db_last_high", 32'(lst[2]), 32'(44));

    // Simultaneous press
    phase_start();
    hold(1, 1, 30);
    hold(0, 0, 12);
    chk("simul_pulse_count", 32'(cnt[0] + cnt[1]), 32'(0));
    chk("simul_up_db_rise", 32'(fst[2]), 32'(5));
    chk("simul_dn_db_rise", 32'(fst[3]), 32'(5));

    // Reset mid-hold
    phase_start();
    hold(0, 1, 12);
    do_reset();
    hold(0, 1, 29);
    chk("rst_first_dec_edge", 32'(fst[1]), 32'(6));
    chk("rst_dec_count", 32'(cnt[1]), 32'(3));
    chk("rst_inc_count", 32'(cnt[0]), 32'(0));
    hold(0, 0, 12);

    // Random segments checked cycle by cycle against the model
    for (int seg = 0; seg < 60; seg++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0: begin
          len = int'($urandom_range(1, 20));
          hold(0, 0, len);
        end
        1: begin
          len = int'($urandom_range(1, 50));
          u = 1'($urandom_range(0, 1));
          hold(u, ~u, len);
        end
        2: begin
          len = int'($urandom_range(1, 12));
          u = 1'($urandom_range(0, 1));
          for (int c = 0; c < len; c++) begin
            d = 1'($urandom_range(0, 1));
            if (u) step(d, 1'b0);
            else step(1'b0, d);
          end
        end
        default: begin
          len = int'($urandom_range(1, 30));
          hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), len);
        end
      endcase
      if ($urandom_range(0, 11) == 0) do_reset();
    end
    hold(0, 0, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

`default_nettype wire
